// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage data-bus sequencer. Issues one load or store per memory-stage
// instruction and keeps the bus request stable until the bus completes it.
// While the access is outstanding it raises stall_m. Load data comes back
// aligned and sign/zero-extended. Misaligned accesses are flagged and are
// never sent to the bus.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_valid             a valid non-NOP instruction is in the memory stage
//   mem_read, mem_write   the instruction is a load / a store
//   mem_addr              effective address
//   mem_wdata             store data, right-justified
//   mem_size              0=byte 1=half 2=word 3=dword (others illegal)
//   mem_signed            sign-extend the load result
//   pipe_advance          the memory stage advances at this edge
//   dreq_valid/addr/size  bus request
//   dreq_strobe           byte-lane write enables (0 for loads)
//   dreq_data             lane-aligned store data
//   dresp_data_ok         bus completes the current request this cycle
//   dresp_data            lane-aligned bus read data
//   stall_m               the memory stage must hold
//   rdata_out             formatted load result
//   misalign              current access is misaligned
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_size,
  input  logic              mem_signed,
  input  logic              pipe_advance,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              stall_m,
  output logic [DATA_W-1:0] rdata_out,
  output logic              misalign
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_size;
  logic [7:0]        cap_strobe;
  logic [DATA_W-1:0] cap_data;
  logic              cap_read;
  logic              cap_signed;
  logic [DATA_W-1:0] result_q;

  logic              is_mem;
  logic              unaligned;
  logic              access;
  logic [2:0]        in_sh;
  logic [7:0]        in_strobe;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] cap_result;

  function automatic logic [7:0] lane_strobe(input logic [2:0] size,
                                             input logic [2:0] sh);
    logic [7:0] s;
    case (size)
      3'd0:    s = 8'h01 << sh;
      3'd1:    s = 8'h03 << sh;
      3'd2:    s = 8'h0F << sh;
      3'd3:    s = 8'hFF;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Bring the addressed lanes down to bit 0, truncate, then extend.
  function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] raw,
                                                    input logic [2:0]        sh,
                                                    input logic [2:0]        size,
                                                    input logic              sgn);
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] r;
    t = raw >> {sh, 3'b000};
    case (size)
      3'd0:    r = {{(DATA_W-8){sgn & t[7]}}, t[7:0]};
      3'd1:    r = {{(DATA_W-16){sgn & t[15]}}, t[15:0]};
      3'd2:    r = {{(DATA_W-32){sgn & t[31]}}, t[31:0]};
      default: r = t;
    endcase
    return r;
  endfunction

  // Alignment check; illegal sizes always count as misaligned.
  always_comb begin
    unaligned = 1'b1;
    case (mem_size)
      3'd0:    unaligned = 1'b0;
      3'd1:    unaligned = mem_addr[0];
      3'd2:    unaligned = |mem_addr[1:0];
      3'd3:    unaligned = |mem_addr[2:0];
      default: unaligned = 1'b1;
    endcase
  end

  assign is_mem     = mem_valid & (mem_read | mem_write);
  assign misalign   = is_mem & unaligned;
  assign access     = is_mem & ~unaligned;
  assign in_sh      = mem_addr[2:0];
  assign in_strobe  = mem_write ? lane_strobe(mem_size, in_sh) : 8'h00;
  assign in_data    = mem_wdata << {in_sh, 3'b000};
  assign in_result  = mem_read ? format_load(dresp_data, in_sh, mem_size, mem_signed)
                               : '0;
  assign cap_result = cap_read ? format_load(dresp_data, cap_addr[2:0], cap_size, cap_signed)
                               : '0;

  // In IDLE the request is a straight pass-through of the inputs so a bus
  // that answers in the same cycle costs no stall. Once in WAIT the captured
  // copy is driven so the request cannot move while the pipe is frozen.
  always_comb begin
    dreq_valid  = 1'b0;
    dreq_addr   = mem_addr;
    dreq_size   = mem_size;
    dreq_strobe = in_strobe;
    dreq_data   = in_data;
    stall_m     = 1'b0;
    rdata_out   = '0;
    case (state)
      ST_IDLE: begin
        dreq_valid = access;
        stall_m    = access & ~dresp_data_ok;
        rdata_out  = (access & dresp_data_ok) ? in_result : '0;
      end
      ST_WAIT: begin
        dreq_valid  = 1'b1;
        dreq_addr   = cap_addr;
        dreq_size   = cap_size;
        dreq_strobe = cap_strobe;
        dreq_data   = cap_data;
        stall_m     = 1'b1;
        rdata_out   = dresp_data_ok ? cap_result : '0;
      end
      ST_DONE: begin
        rdata_out = result_q;
      end
      default: ;
    endcase
  end

  // DONE exists so a completed access is not reissued while some other
  // hazard keeps the memory stage frozen; it is left only when the pipe
  // advances, so a new instruction is first seen the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cap_addr   <= '0;
      cap_size   <= '0;
      cap_strobe <= '0;
      cap_data   <= '0;
      cap_read   <= 1'b0;
      cap_signed <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (!dresp_data_ok) begin
              cap_addr   <= mem_addr;
              cap_size   <= mem_size;
              cap_strobe <= in_strobe;
              cap_data   <= in_data;
              cap_read   <= mem_read;
              cap_signed <= mem_signed;
              state      <= ST_WAIT;
            end else if (!pipe_advance) begin
              result_q <= in_result;
              state    <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (dresp_data_ok) begin
            result_q <= cap_result;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (pipe_advance) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. Expected load results are pushed to a
// scoreboard queue when the instruction is driven and popped when the DUT
// presents the result; other outputs are compared against constants.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_signed;
  logic        pipe_advance;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall_m;
  logic [63:0] rdata_out;
  logic        misalign;

  int          checks;
  int          errors;
  int          stall_cycles;
  logic [63:0] exp_q[$];

  mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_size     (mem_size),
    .mem_signed   (mem_signed),
    .pipe_advance (pipe_advance),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .stall_m      (stall_m),
    .rdata_out    (rdata_out),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive every input, then let combinational outputs settle well before
  // the next rising edge.
  task automatic applyStimulus(input logic        valid,
                               input logic        rd,
                               input logic        wr,
                               input logic [63:0] addr,
                               input logic [2:0]  size,
                               input logic        sgn,
                               input logic [63:0] wdata,
                               input logic        adv,
                               input logic        dok,
                               input logic [63:0] rsp);
    mem_valid     = valid;
    mem_read      = rd;
    mem_write     = wr;
    mem_addr      = addr;
    mem_size      = size;
    mem_signed    = sgn;
    mem_wdata     = wdata;
    pipe_advance  = adv;
    dresp_data_ok = dok;
    dresp_data    = rsp;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic popCheck(input string tag);
    logic [63:0] exp_v;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=<empty scoreboard>", tag, rdata_out);
    end else begin
      exp_v = exp_q.pop_front();
      checkOutput(tag, rdata_out, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyIdle();
    nextCycle();
    nextCycle();
    reset = 1'b0;
    applyIdle();
    checkOutput("reset_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    checkOutput("reset_stall", {63'b0, stall_m}, 64'd0);
    checkOutput("reset_rdata", rdata_out, 64'd0);
    checkOutput("reset_misalign", {63'b0, misalign}, 64'd0);

    // lb 0x1003 signed, response on the third stalled cycle.
    nextCycle();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
    stall_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h1003, 3'd0, 1'b1, 64'h0, 1'b0,
                    (c == 2), 64'h0000_0000_8000_0000);
      if (stall_m) stall_cycles++;
      checkOutput("lb_dreq_valid", {63'b0, dreq_valid}, 64'd1);
      checkOutput("lb_dreq_addr", dreq_addr, 64'h1003);
      checkOutput("lb_dreq_size", {61'b0, dreq_size}, 64'd0);
      checkOutput("lb_dreq_strobe", {56'b0, dreq_strobe}, 64'd0);
      nextCycle();
    end
    checkOutput("lb_stall_cycles", 64'(stall_cycles), 64'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h1003, 3'd0, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0);
    checkOutput("lb_done_stall", {63'b0, stall_m}, 64'd0);
    checkOutput("lb_done_valid", {63'b0, dreq_valid}, 64'd0);
    popCheck("lb_rdata");
    nextCycle();

    // sh 0x2006 completed in the issue cycle while the pipe advances.
    exp_q.push_back(64'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h2006, 3'd1, 1'b0, 64'hABCD, 1'b1, 1'b1, 64'h0);
    checkOutput("sh_dreq_valid", {63'b0, dreq_valid}, 64'd1);
    checkOutput("sh_strobe", {56'b0, dreq_strobe}, 64'hC0);
    checkOutput("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
    checkOutput("sh_stall", {63'b0, stall_m}, 64'd0);
    popCheck("sh_rdata");
    nextCycle();
    // Still IDLE: a fresh access is passed straight through to the bus.
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h3000, 3'd3, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("sh_after_idle_valid", {63'b0, dreq_valid}, 64'd1);
    checkOutput("sh_after_idle_addr", dreq_addr, 64'h3000);
    applyIdle();
    nextCycle();
    nextCycle();

    // lwu 0x10 completing in WAIT, then frozen for four cycles.
    exp_q.push_back(64'h0000_0000_DEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("lwu_issue_stall", {63'b0, stall_m}, 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 3'd2, 1'b0, 64'h0, 1'b0, 1'b1,
                  64'hFFFF_FFFF_DEAD_BEEF);
    checkOutput("lwu_wait_stall", {63'b0, stall_m}, 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    popCheck("lwu_rdata");
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      checkOutput("lwu_hold_valid", {63'b0, dreq_valid}, 64'd0);
      checkOutput("lwu_hold_stall", {63'b0, stall_m}, 64'd0);
      checkOutput("lwu_hold_rdata", rdata_out, 64'h0000_0000_DEAD_BEEF);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 3'd2, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    applyIdle();

    // lh 0x3002 signed, same-cycle response with the pipe frozen.
    exp_q.push_back(64'hFFFF_FFFF_FFFF_8001);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h3002, 3'd1, 1'b1, 64'h0, 1'b0, 1'b1,
                  64'h0000_0000_8001_0000);
    checkOutput("lh_stall", {63'b0, stall_m}, 64'd0);
    popCheck("lh_rdata_now");
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h3002, 3'd1, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0);
    checkOutput("lh_done_rdata", rdata_out, 64'hFFFF_FFFF_FFFF_8001);
    checkOutput("lh_done_valid", {63'b0, dreq_valid}, 64'd0);
    nextCycle();

    // Misaligned dword and illegal size.
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h104, 3'd3, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    checkOutput("ld_mis_flag", {63'b0, misalign}, 64'd1);
    checkOutput("ld_mis_valid", {63'b0, dreq_valid}, 64'd0);
    checkOutput("ld_mis_stall", {63'b0, stall_m}, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h100, 3'd5, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("size5_mis_flag", {63'b0, misalign}, 64'd1);
    nextCycle();
    applyIdle();
    nextCycle();

    // Reset during WAIT, then a stale response with no instruction.
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h20, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h20, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 64'h0, 1'b0, 1'b1,
                  64'h1234_5678_9ABC_DEF0);
    checkOutput("rst_wait_valid", {63'b0, dreq_valid}, 64'd0);
    checkOutput("rst_wait_stall", {63'b0, stall_m}, 64'd0);
    checkOutput("rst_wait_rdata", rdata_out, 64'd0);
    nextCycle();
    applyIdle();
    checkOutput("rst_after_rdata", rdata_out, 64'd0);
    nextCycle();

    // ld 0x40 with the inputs moving to 0x80 mid-WAIT.
    exp_q.push_back(64'h1122_3344_5566_7788);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h40, 3'd3, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h80, 3'd0, 1'b1, 64'hFF, 1'b0, 1'b0, 64'h0);
    checkOutput("chg_addr_wait", dreq_addr, 64'h40);
    checkOutput("chg_size_wait", {61'b0, dreq_size}, 64'd3);
    checkOutput("chg_strobe_wait", {56'b0, dreq_strobe}, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h80, 3'd0, 1'b1, 64'hFF, 1'b0, 1'b1,
                  64'h1122_3344_5566_7788);
    checkOutput("chg_addr_dok", dreq_addr, 64'h40);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h40, 3'd3, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    popCheck("chg_rdata");
    nextCycle();
    applyIdle();
    nextCycle();

    // sb 0x45 held in WAIT: captured strobe and shifted data must persist.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h45, 3'd0, 1'b0, 64'h5A, 1'b0, 1'b0, 64'h0);
    checkOutput("sb_issue_strobe", {56'b0, dreq_strobe}, 64'h20);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 3'd3, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("sb_wait_strobe", {56'b0, dreq_strobe}, 64'h20);
    checkOutput("sb_wait_data", dreq_data, 64'h0000_5A00_0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 3'd3, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h45, 3'd0, 1'b0, 64'h5A, 1'b1, 1'b0, 64'h0);
    checkOutput("sb_done_rdata", rdata_out, 64'd0);
    checkOutput("sb_done_valid", {63'b0, dreq_valid}, 64'd0);
    nextCycle();
    applyIdle();

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
